priority_encoder_8x3: RTL and testbench
=======================================

PRIORITY_ENCODER_8X3 -- requirements
Module: priority_encoder_8x3

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = lowest index wins, 0 = highest index wins.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have req  input  8  event lines, sampled every cycle, active-high.
REQ-006 SHALL have mask  input  8  1 = line excluded from selection (still captured).
REQ-007 SHALL have ovf_clr  input  1  clears overflow.
REQ-008 SHALL have out_ready  input  1  consumer accepts code.
REQ-009 SHALL have out_valid  output  1  out_code holds a pending index.
REQ-010 SHALL have out_code  output  3  binary index of selected line.
REQ-011 SHALL have pending  output  8  captured, unserviced lines.
REQ-012 SHALL have overflow  output  1  sticky lost-event flag.

Function
REQ-013 SHALL capture events: pending_next = pending | req, minus the bit being accepted this cycle.
REQ-014 SHALL compute eligible = pending & ~mask; select per LSB_FIRST; ineligible bits wait.
REQ-015 SHALL implement FSM IDLE/VALID; out_valid = (state == VALID).
REQ-016 SHALL in IDLE with eligible != 0: load out_code with selected index, go VALID.
REQ-017 SHALL in IDLE with eligible == 0: stay IDLE; out_code holds last value.
REQ-018 SHALL in VALID hold out_code stable until out_valid && out_ready, regardless of mask or new req.
REQ-019 SHALL on accept clear pending[out_code]; if req[out_code] is high that cycle, the bit stays set (new event).
REQ-020 SHALL on accept reload out_code from eligible computed with the accepted bit cleared and the same-cycle req ORed in; stay VALID if nonzero, else go IDLE (back-to-back, no bubble).
REQ-021 SHALL have latency: req high in cycle N -> pending bit set at N+1 -> out_valid at N+2 (from IDLE).
REQ-022 SHALL set overflow when req[i] is high while pending[i] is already 1 and bit i is not being accepted that cycle.
REQ-023 SHALL give set priority over ovf_clr when both occur in the same cycle.
REQ-024 SHALL fix out_code to 3 bits, wrap-free; index 7 is a legal code with no special case.

Reset
REQ-025 SHALL on rst: state=IDLE, out_valid=0, out_code=3'b000, pending=8'h00, overflow=0; req that cycle is discarded.
REQ-026 SHALL let rst in VALID abort the transfer; the code is dropped and not re-presented.

Structure
REQ-027 SHALL have package priority_encoder_pkg holding N_REQ=8, CODE_W=3, the state enum typedef, and a one-hot/priority-to-binary function.
REQ-028 SHALL have one combinational sub-module prio_sel8 (eligible vector + LSB_FIRST -> any, index); FSM and registers stay in the top.

Verification
REQ-029 SHALL cover: req=8'h24 one cycle, mask=0, ready=1, LSB_FIRST=1 -> code 2 then 5 on consecutive cycles, then IDLE; pending 8'h24 -> 8'h20 -> 8'h00.
REQ-030 SHALL cover: LSB_FIRST=0, req=8'h81, ready=1 -> code 7 then 0.
REQ-031 SHALL cover: req=8'h10, ready=0 for 5 cycles while mask=8'h10 and req=8'h01 is added -> out_code stays 4; after accept -> code 0.
REQ-032 SHALL cover: req[3] pulsed twice while pending[3]=1, ready=0 -> overflow=1; ovf_clr -> 0; ovf_clr with a simultaneous second overflow -> stays 1.
REQ-033 SHALL cover: accept of code 6 in the same cycle as req[6]=1 -> pending[6] stays 1, code 6 re-presented next cycle, overflow=0.
REQ-034 SHALL cover: rst asserted while VALID with pending=8'hFF -> next cycle all outputs are at reset values.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_pkg
// Description : Shared sizes, FSM state type and priority helpers for the
//               8-to-3 priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package priority_encoder_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    // Return the index of the winning set bit.
    // lsb_first = 1: the lowest set index wins.
    // lsb_first = 0: the highest set index wins.
    // An all-zero vector returns 0; callers qualify the result with an
    // "any bit set" flag.
    function automatic logic [CODE_W-1:0] prio_to_bin(
        input logic [N_REQ-1:0] vec,
        input logic             lsb_first
    );
        logic [CODE_W-1:0] idx;
        idx = '0;
        if (lsb_first) begin
            // Scan downwards so that the last match is the lowest index.
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end else begin
            // Scan upwards so that the last match is the highest index.
            for (int i = 0; i < N_REQ; i++) begin
                if (vec[i]) idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // Convert a binary index into a one-hot line vector.
    function automatic logic [N_REQ-1:0] bin_to_onehot(input logic [CODE_W-1:0] code);
        return {{(N_REQ-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_8x3_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8x3_if
// Description : Event, mask and code-handshake bundle for the priority
//               encoder.
//               master : drives req, mask, ovf_clr and out_ready;
//                        observes out_valid, out_code, pending and overflow.
//               slave  : the encoder side of the same bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_encoder_8x3_if;
    import priority_encoder_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  mask;
    logic              ovf_clr;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic [N_REQ-1:0]  pending;
    logic              overflow;

    modport master (
        output req, mask, ovf_clr, out_ready,
        input  out_valid, out_code, pending, overflow
    );

    modport slave (
        input  req, mask, ovf_clr, out_ready,
        output out_valid, out_code, pending, overflow
    );

endinterface
`default_nettype wire

// File: rtl/prio_sel8.sv
`default_nettype none
// ============================================================================
// Module      : prio_sel8
// Description : Combinational 8-line priority selector.
//   i_eligible : candidate lines
//   o_any      : at least one candidate line is set
//   o_index    : binary index of the winner (LSB_FIRST picks the direction)
// Revision    : 1.0 - initial release
// ============================================================================
module prio_sel8
    import priority_encoder_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  wire logic [N_REQ-1:0]  i_eligible,
    output logic                   o_any,
    output logic [CODE_W-1:0]      o_index
);

    assign o_any   = |i_eligible;
    assign o_index = prio_to_bin(i_eligible, LSB_FIRST != 0);

endmodule
`default_nettype wire

// File: rtl/priority_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8x3
// Description : Captures event lines into a pending register and presents
//               the highest-priority unmasked pending line as a 3-bit code
//               on a valid/ready handshake. A sticky overflow flag records
//               events that hit a line that is already pending.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of priority_encoder_8x3_if
//         (req, mask, ovf_clr, out_ready -> out_valid, out_code, pending,
//          overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_8x3
    import priority_encoder_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    priority_encoder_8x3_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic [N_REQ-1:0]  r_pending;
    logic [N_REQ-1:0]  w_pending_nxt;
    logic              r_overflow;
    logic              w_overflow_nxt;

    logic              w_accept;
    logic [N_REQ-1:0]  w_acc_bit;
    logic [N_REQ-1:0]  w_elig;
    logic              w_any;
    logic [CODE_W-1:0] w_sel;
    logic              w_ovf_set;

    // The presented code is consumed this cycle.
    assign w_accept  = (r_state == ST_VALID) && bus.out_ready;
    assign w_acc_bit = w_accept ? bin_to_onehot(r_code) : '0;

    // Clearing the accepted bit before ORing in req lets a new event on the
    // same line survive the accept.
    assign w_pending_nxt = (r_pending & ~w_acc_bit) | bus.req;

    // From IDLE only registered pending lines compete, which gives the
    // two-cycle req-to-valid latency. On an accept the reload looks at the
    // post-accept vector, so back-to-back codes need no idle cycle. Outside
    // those two cases the selector result is ignored.
    assign w_elig = w_accept ? (w_pending_nxt & ~bus.mask)
                             : (r_pending & ~bus.mask);

    prio_sel8 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_prio_sel8 (
        .i_eligible (w_elig),
        .o_any      (w_any),
        .o_index    (w_sel)
    );

    // An event is lost when it lands on a line that is still pending and is
    // not being retired in the same cycle. Setting wins over clearing.
    assign w_ovf_set      = |(bus.req & r_pending & ~w_acc_bit);
    assign w_overflow_nxt = w_ovf_set | (r_overflow & ~bus.ovf_clr);

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_VALID;
                    w_code_nxt  = w_sel;
                end
            end
            ST_VALID: begin
                // The code stays frozen until it is accepted.
                if (w_accept) begin
                    if (w_any) begin
                        w_code_nxt = w_sel;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_code     <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign bus.out_valid = (r_state == ST_VALID);
    assign bus.out_code  = r_code;
    assign bus.pending   = r_pending;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_8x3
// Description : Self-checking bench for priority_encoder_8x3. One instance
//               uses lowest-index priority, a second uses highest-index
//               priority. Accepted codes are checked against a queue of
//               expected codes; state is checked after every step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_8x3;

    logic clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];

    priority_encoder_8x3_if if_a ();
    priority_encoder_8x3_if if_b ();

    priority_encoder_8x3 #(.LSB_FIRST(1)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    priority_encoder_8x3 #(.LSB_FIRST(0)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within bound");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The handshake is stable at the falling edge; an accept there is the
    // accept that the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && if_a.out_valid && if_a.out_ready) begin
            if (q_a.size() == 0) begin
                check("sb_a_unexpected_accept", {29'd0, if_a.out_code}, 32'hFFFF_FFFF);
            end else begin
                check("sb_a_code", {29'd0, if_a.out_code}, {29'd0, q_a.pop_front()});
            end
        end
        if (!rst && if_b.out_valid && if_b.out_ready) begin
            if (q_b.size() == 0) begin
                check("sb_b_unexpected_accept", {29'd0, if_b.out_code}, 32'hFFFF_FFFF);
            end else begin
                check("sb_b_code", {29'd0, if_b.out_code}, {29'd0, q_b.pop_front()});
            end
        end
    end

    initial begin
        // ---------------- reset, with req discarded ----------------
        rst = 1'b1;
        if_a.req = 8'hFF; if_a.mask = 8'h00; if_a.ovf_clr = 1'b0; if_a.out_ready = 1'b0;
        if_b.req = 8'h00; if_b.mask = 8'h00; if_b.ovf_clr = 1'b0; if_b.out_ready = 1'b0;
        tick();
        check("rst_valid",    {31'd0, if_a.out_valid}, 32'd0);
        check("rst_code",     {29'd0, if_a.out_code},  32'd0);
        check("rst_pending",  {24'd0, if_a.pending},   32'h00);
        check("rst_overflow", {31'd0, if_a.overflow},  32'd0);
        rst = 1'b0; if_a.req = 8'h00;
        tick();
        check("rst_req_dropped", {24'd0, if_a.pending},   32'h00);
        check("rst_still_idle",  {31'd0, if_a.out_valid}, 32'd0);

        // ---------------- two events, back-to-back codes ----------------
        if_a.out_ready = 1'b1;
        q_a.push_back(3'd2); q_a.push_back(3'd5);
        if_a.req = 8'h24;
        tick();
        check("bb_pend_n1",  {24'd0, if_a.pending},   32'h24);
        check("bb_valid_n1", {31'd0, if_a.out_valid}, 32'd0);
        if_a.req = 8'h00;
        tick();
        check("bb_valid_n2", {31'd0, if_a.out_valid}, 32'd1);
        check("bb_code_2",   {29'd0, if_a.out_code},  32'd2);
        check("bb_pend_24",  {24'd0, if_a.pending},   32'h24);
        tick();
        check("bb_valid_5",  {31'd0, if_a.out_valid}, 32'd1);
        check("bb_code_5",   {29'd0, if_a.out_code},  32'd5);
        check("bb_pend_20",  {24'd0, if_a.pending},   32'h20);
        tick();
        check("bb_idle",     {31'd0, if_a.out_valid}, 32'd0);
        check("bb_pend_00",  {24'd0, if_a.pending},   32'h00);
        check("bb_code_hold",{29'd0, if_a.out_code},  32'd5);

        // ---------------- code held under mask and new req ----------------
        if_a.out_ready = 1'b0;
        if_a.req = 8'h10;
        tick();
        if_a.req = 8'h00;
        tick();
        check("hold_code_4", {29'd0, if_a.out_code}, 32'd4);
        if_a.mask = 8'h10; if_a.req = 8'h01;
        tick();
        if_a.req = 8'h00;
        check("hold_pend_11", {24'd0, if_a.pending}, 32'h11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_code_stable", {29'd0, if_a.out_code},  32'd4);
            check("hold_valid",       {31'd0, if_a.out_valid}, 32'd1);
        end
        q_a.push_back(3'd4); q_a.push_back(3'd0);
        if_a.out_ready = 1'b1;
        tick();
        check("hold_next_code_0", {29'd0, if_a.out_code}, 32'd0);
        check("hold_pend_01",     {24'd0, if_a.pending},  32'h01);
        tick();
        check("hold_idle", {31'd0, if_a.out_valid}, 32'd0);
        if_a.out_ready = 1'b0; if_a.mask = 8'h00;

        // ---------------- overflow set / clear / set-wins ----------------
        if_a.req = 8'h08;
        tick();
        if_a.req = 8'h00;
        tick();
        check("ovf_none_yet", {31'd0, if_a.overflow}, 32'd0);
        if_a.req = 8'h08;
        tick();
        check("ovf_set", {31'd0, if_a.overflow}, 32'd1);
        if_a.req = 8'h00;
        tick();
        if_a.req = 8'h08;
        tick();
        check("ovf_sticky", {31'd0, if_a.overflow}, 32'd1);
        if_a.req = 8'h00; if_a.ovf_clr = 1'b1;
        tick();
        check("ovf_cleared", {31'd0, if_a.overflow}, 32'd0);
        if_a.req = 8'h08;
        tick();
        check("ovf_set_wins", {31'd0, if_a.overflow}, 32'd1);
        if_a.req = 8'h00; if_a.ovf_clr = 1'b0;
        q_a.push_back(3'd3);
        if_a.out_ready = 1'b1;
        tick();
        check("ovf_drain_idle", {31'd0, if_a.out_valid}, 32'd0);
        if_a.out_ready = 1'b0; if_a.ovf_clr = 1'b1;
        tick();
        if_a.ovf_clr = 1'b0;

        // ---------------- accept with same-line req ----------------
        if_a.req = 8'h40;
        tick();
        if_a.req = 8'h00;
        tick();
        check("re_code_6", {29'd0, if_a.out_code}, 32'd6);
        q_a.push_back(3'd6); q_a.push_back(3'd6);
        if_a.out_ready = 1'b1; if_a.req = 8'h40;
        tick();
        check("re_pend_40",  {24'd0, if_a.pending},   32'h40);
        check("re_valid",    {31'd0, if_a.out_valid}, 32'd1);
        check("re_code_6b",  {29'd0, if_a.out_code},  32'd6);
        check("re_no_ovf",   {31'd0, if_a.overflow},  32'd0);
        if_a.req = 8'h00;
        tick();
        check("re_idle",     {31'd0, if_a.out_valid}, 32'd0);
        check("re_pend_00",  {24'd0, if_a.pending},   32'h00);
        if_a.out_ready = 1'b0;

        // ---------------- highest-index priority ----------------
        if_b.out_ready = 1'b1;
        q_b.push_back(3'd7); q_b.push_back(3'd0);
        if_b.req = 8'h81;
        tick();
        if_b.req = 8'h00;
        tick();
        check("msb_code_7", {29'd0, if_b.out_code}, 32'd7);
        tick();
        check("msb_code_0",  {29'd0, if_b.out_code}, 32'd0);
        check("msb_pend_01", {24'd0, if_b.pending},  32'h01);
        tick();
        check("msb_idle", {31'd0, if_b.out_valid}, 32'd0);
        if_b.out_ready = 1'b0;

        // ---------------- reset aborts a valid transfer ----------------
        if_a.req = 8'hFF;
        tick();
        if_a.req = 8'h00;
        tick();
        check("abort_pend_ff", {24'd0, if_a.pending},   32'hFF);
        check("abort_valid",   {31'd0, if_a.out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort_rst_valid",   {31'd0, if_a.out_valid}, 32'd0);
        check("abort_rst_code",    {29'd0, if_a.out_code},  32'd0);
        check("abort_rst_pending", {24'd0, if_a.pending},   32'h00);
        check("abort_rst_ovf",     {31'd0, if_a.overflow},  32'd0);
        rst = 1'b0;
        tick();
        check("abort_not_represented", {31'd0, if_a.out_valid}, 32'd0);

        // Every expected code must have been consumed.
        check("sb_a_drained", q_a.size(), 32'd0);
        check("sb_b_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
